// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared mask encodings, FSM state type and access helpers
// Purpose: funct3 access-size encodings, the responder state enum, and small
//          pure functions for legality checks and store lane steering.
// Ports:   none (package).
package mem_pkg;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned halfword/word or an encoding outside the legal set.
  function automatic logic access_illegal(input logic [2:0] mask, input logic [1:0] lo);
    case (mask)
      MASK_B, MASK_BU: access_illegal = 1'b0;
      MASK_H, MASK_HU: access_illegal = lo[0];
      MASK_W:          access_illegal = (lo != 2'b00);
      default:         access_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [2:0] mask, input logic [1:0] lo);
    case (mask)
      MASK_B, MASK_BU: lane_enables = 4'b0001 << lo;
      MASK_H, MASK_HU: lane_enables = lo[1] ? 4'b1100 : 4'b0011;
      MASK_W:          lane_enables = 4'b1111;
      default:         lane_enables = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] store_lanes(input logic [2:0] mask, input logic [31:0] data);
    case (mask)
      MASK_B, MASK_BU: store_lanes = {4{data[7:0]}};
      MASK_H, MASK_HU: store_lanes = {2{data[15:0]}};
      default:         store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/load_ext.sv
// rtl/load_ext.sv - load alignment and sign/zero extension
// Purpose: selects the addressed byte/halfword from a 32-bit word and extends it.
// Ports:   word    in  32  raw word read from the array
//          addr_lo in  2   byte offset within the word
//          mask    in  3   funct3 access size
//          result  out 32  extended load value (0 for illegal encodings)
import mem_pkg::*;

module load_ext (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  mask,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = word >> {addr_lo, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (mask)
      MASK_B:  result = {{24{byte_sel[7]}}, byte_sel};
      MASK_BU: result = {24'd0, byte_sel};
      MASK_H:  result = {{16{half_sel[15]}}, half_sel};
      MASK_HU: result = {16'd0, half_sel};
      MASK_W:  result = word;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data memory responder for the M stage
// Purpose: accepts one load/store, inserts WAIT_CYCLES wait states, performs a
//          byte-lane access and returns a one-cycle response.
// Ports:   clk       in  1   clock
//          rst       in  1   synchronous active-low reset
//          mem_rd    in  1   load request
//          mem_wr    in  1   store request (wins over mem_rd)
//          addr      in  32  byte address
//          wr_data   in  32  right-aligned store data
//          mask      in  3   funct3 access size
//          busy      out 1   pipeline stall
//          rsp_valid out 1   access complete pulse
//          rd_data   out 32  extended load data
//          err       out 1   misaligned / illegal access
import mem_pkg::*;

module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic [2:0]  mask,
  output logic        busy,
  output logic        rsp_valid,
  output logic [31:0] rd_data,
  output logic        err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t         state, state_nx;
  logic [3:0]     cnt;
  logic [AW+1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic [2:0]     mask_q;
  logic           store_q, err_q;

  logic           req, req_bad, in_idle, access;
  logic [AW+1:0]  cur_addr;
  logic [31:0]    cur_wdata;
  logic [2:0]     cur_mask;
  logic           cur_store;
  logic [AW-1:0]  idx;
  logic [3:0]     lane_we;
  logic [31:0]    lane_wdata;
  logic           rd_en;
  logic [31:0]    rd_word, ext_word;
  logic           addr_unused;

  assign addr_unused = ^addr[31:AW+2];

  assign req     = mem_rd | mem_wr;
  assign req_bad = access_illegal(mask, addr[1:0]);
  assign in_idle = (state == IDLE);

  // With zero wait states the array is accessed on the accepting edge, before
  // the request has been latched, so the live inputs feed the array directly.
  assign cur_addr  = in_idle ? addr[AW+1:0] : addr_q;
  assign cur_wdata = in_idle ? wr_data      : wdata_q;
  assign cur_mask  = in_idle ? mask         : mask_q;
  assign cur_store = in_idle ? mem_wr       : store_q;
  assign idx       = cur_addr[AW+1:2];

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    access   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          busy = 1'b1;
          if (req_bad) begin
            state_nx = RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
            access   = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd1) begin
          state_nx = RESP;
          access   = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      mask_q  <= 3'd0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr[AW+1:0];
            wdata_q <= wr_data;
            mask_q  <= mask;
            store_q <= mem_wr;
            err_q   <= req_bad;
            cnt     <= (state_nx == WAIT) ? WAIT_INIT : 4'd0;
          end
        end
        WAIT:    cnt <= cnt - 4'd1;
        default: ;
      endcase
    end
  end

  // Gating by rst means a reset on the would-be access edge aborts the write.
  assign lane_we    = (access && rst && cur_store) ? lane_enables(cur_mask, cur_addr[1:0]) : 4'b0000;
  assign lane_wdata = store_lanes(cur_mask, cur_wdata);
  assign rd_en      = access && rst && !cur_store;

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] ram [DEPTH];
    logic [7:0] q;
    always_ff @(posedge clk) begin
      if (lane_we[l]) ram[idx] <= lane_wdata[8*l +: 8];
      if (rd_en)      q <= ram[idx];
    end
    assign rd_word[8*l +: 8] = q;
  end

  load_ext u_load_ext (
    .word    (rd_word),
    .addr_lo (addr_q[1:0]),
    .mask    (mask_q),
    .result  (ext_word)
  );

  always_comb begin
    rsp_valid = (state == RESP);
    err       = rsp_valid && err_q;
    rd_data   = (rsp_valid && !store_q && !err_q) ? ext_word : 32'd0;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
// Purpose: exercises word/byte/halfword access, errors, reset abort, aliasing
//          and zero-wait back-to-back traffic on two parameterisations.
// Ports:   none (top-level bench).
import mem_pkg::*;

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd = 1'b0, mem_wr = 1'b0;
  logic [31:0] addr = 32'd0, wr_data = 32'd0;
  logic [2:0]  mask = 3'd0;
  logic        busy, rsp_valid, err;
  logic [31:0] rd_data;

  logic        rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic [2:0]  mask0 = 3'd0;
  logic        busy0, rsp0, err0;
  logic [31:0] rdd0;

  int compared = 0;
  int failed   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
    .wr_data(wr_data), .mask(mask), .busy(busy), .rsp_valid(rsp_valid),
    .rd_data(rd_data), .err(err)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_rd(rd0), .mem_wr(wr0), .addr(addr0),
    .wr_data(wdata0), .mask(mask0), .busy(busy0), .rsp_valid(rsp0),
    .rd_data(rdd0), .err(err0)
  );

  // Presents one request to dut, holding it until the response edge.
  // lat counts cycles from the request cycle (0) to the rsp_valid cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] m,
                        output logic [31:0] rdat, output logic e,
                        output int lat, output int bcnt, output bit dirty);
    bit done;
    done = 0; lat = -1; bcnt = 0; dirty = 0; rdat = 32'd0; e = 1'b0;
    mem_rd = rd; mem_wr = wr; addr = a; wr_data = d; mask = m;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (rsp_valid) begin
        done = 1; lat = k; rdat = rd_data; e = err;
      end else if (rd_data !== 32'd0 || err !== 1'b0) begin
        dirty = 1;
      end
      @(posedge clk); #1;
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if (rsp_valid !== 1'b0) begin failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    compared++; if (err !== 1'b0) begin failed++; $display("FAIL reset_err: got %b want 0", err); end
    compared++; if (rd_data !== 32'd0) begin failed++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    compared++; if (rsp0 !== 1'b0 || busy0 !== 1'b0) begin failed++; $display("FAIL reset_dut0: got rsp=%b busy=%b want 0 0", rsp0, busy0); end
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] r; logic e; int lat, bc; bit dirty;
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, MASK_W, r, e, lat, bc, dirty);
    compared++; if (lat !== 3) begin failed++; $display("FAIL sw_latency: got %0d want 3", lat); end
    compared++; if (r !== 32'd0) begin failed++; $display("FAIL sw_rd_data: got %h want 0", r); end
    access(1'b1, 1'b0, 32'h10, 32'h0, MASK_W, r, e, lat, bc, dirty);
    compared++; if (r !== 32'hDEADBEEF) begin failed++; $display("FAIL lw_data: got %h want deadbeef", r); end
    compared++; if (lat !== 3) begin failed++; $display("FAIL lw_latency: got %0d want 3", lat); end
    compared++; if (bc !== 3) begin failed++; $display("FAIL lw_busy_cycles: got %0d want 3", bc); end
    compared++; if (e !== 1'b0) begin failed++; $display("FAIL lw_err: got %b want 0", e); end
    compared++; if (dirty !== 1'b0) begin failed++; $display("FAIL lw_idle_outputs: got %b want 0", dirty); end
  endtask

  task automatic test_byte();
    logic [31:0] r; logic e; int lat, bc; bit dirty;
    access(1'b0, 1'b1, 32'h10, 32'h00000000, MASK_W, r, e, lat, bc, dirty);
    access(1'b0, 1'b1, 32'h13, 32'hFFFFFF80, MASK_B, r, e, lat, bc, dirty);
    access(1'b1, 1'b0, 32'h13, 32'h0, MASK_B, r, e, lat, bc, dirty);
    compared++; if (r !== 32'hFFFFFF80) begin failed++; $display("FAIL lb_sext: got %h want ffffff80", r); end
    access(1'b1, 1'b0, 32'h13, 32'h0, MASK_BU, r, e, lat, bc, dirty);
    compared++; if (r !== 32'h00000080) begin failed++; $display("FAIL lbu_zext: got %h want 00000080", r); end
    access(1'b1, 1'b0, 32'h10, 32'h0, MASK_W, r, e, lat, bc, dirty);
    compared++; if (r !== 32'h80000000) begin failed++; $display("FAIL sb_lanes: got %h want 80000000", r); end
  endtask

  task automatic test_half();
    logic [31:0] r; logic e; int lat, bc; bit dirty;
    access(1'b0, 1'b1, 32'h22, 32'h1234BEEF, MASK_H, r, e, lat, bc, dirty);
    access(1'b1, 1'b0, 32'h22, 32'h0, MASK_H, r, e, lat, bc, dirty);
    compared++; if (r !== 32'hFFFFBEEF) begin failed++; $display("FAIL lh_sext: got %h want ffffbeef", r); end
    access(1'b1, 1'b0, 32'h22, 32'h0, MASK_HU, r, e, lat, bc, dirty);
    compared++; if (r !== 32'h0000BEEF) begin failed++; $display("FAIL lhu_zext: got %h want 0000beef", r); end
    access(1'b1, 1'b0, 32'h23, 32'h0, MASK_BU, r, e, lat, bc, dirty);
    compared++; if (r !== 32'h000000BE) begin failed++; $display("FAIL lbu_hi_lane: got %h want 000000be", r); end
  endtask

  task automatic test_misaligned();
    logic [31:0] r; logic e; int lat, bc; bit dirty;
    access(1'b1, 1'b0, 32'h11, 32'h0, MASK_W, r, e, lat, bc, dirty);
    compared++; if (e !== 1'b1) begin failed++; $display("FAIL lw_mis_err: got %b want 1", e); end
    compared++; if (r !== 32'd0) begin failed++; $display("FAIL lw_mis_data: got %h want 0", r); end
    compared++; if (lat !== 1) begin failed++; $display("FAIL lw_mis_latency: got %0d want 1", lat); end
    access(1'b1, 1'b0, 32'h21, 32'h0, MASK_HU, r, e, lat, bc, dirty);
    compared++; if (e !== 1'b1) begin failed++; $display("FAIL lhu_mis_err: got %b want 1", e); end
    access(1'b1, 1'b0, 32'h10, 32'h0, 3'b011, r, e, lat, bc, dirty);
    compared++; if (e !== 1'b1 || lat !== 1) begin failed++; $display("FAIL bad_mask: got err=%b lat=%0d want 1 1", e, lat); end
    access(1'b0, 1'b1, 32'h12, 32'hFFFFFFFF, MASK_W, r, e, lat, bc, dirty);
    compared++; if (e !== 1'b1) begin failed++; $display("FAIL sw_mis_err: got %b want 1", e); end
    access(1'b1, 1'b0, 32'h10, 32'h0, MASK_W, r, e, lat, bc, dirty);
    compared++; if (r !== 32'h80000000) begin failed++; $display("FAIL mis_unchanged: got %h want 80000000", r); end
  endtask

  task automatic test_reset_wait();
    logic [31:0] r; logic e; int lat, bc; bit dirty;
    access(1'b0, 1'b1, 32'h40, 32'h11111111, MASK_W, r, e, lat, bc, dirty);
    mem_wr = 1'b1; addr = 32'h40; wr_data = 32'h12345678; mask = MASK_W;
    @(posedge clk); #1;
    mem_wr = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 1'b1) begin failed++; $display("FAIL wait_busy: got %b want 1", busy); end
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    compared++; if ({busy, rsp_valid, err} !== 3'b000 || rd_data !== 32'd0)
      begin failed++; $display("FAIL abort_outputs: got busy=%b rsp=%b err=%b rd=%h want all 0", busy, rsp_valid, err, rd_data); end
    @(posedge clk); #1;
    access(1'b1, 1'b0, 32'h40, 32'h0, MASK_W, r, e, lat, bc, dirty);
    compared++; if (r !== 32'h11111111) begin failed++; $display("FAIL abort_no_write: got %h want 11111111", r); end
  endtask

  task automatic test_wrap_and_both();
    logic [31:0] r; logic e; int lat, bc; bit dirty;
    access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, MASK_W, r, e, lat, bc, dirty);
    access(1'b1, 1'b0, 32'h000, 32'h0, MASK_W, r, e, lat, bc, dirty);
    compared++; if (r !== 32'hA5A5A5A5) begin failed++; $display("FAIL wrap_alias: got %h want a5a5a5a5", r); end
    access(1'b1, 1'b1, 32'h50, 32'hCAFEF00D, MASK_W, r, e, lat, bc, dirty);
    compared++; if (r !== 32'd0) begin failed++; $display("FAIL both_rd_data: got %h want 0", r); end
    access(1'b1, 1'b0, 32'h50, 32'h0, MASK_W, r, e, lat, bc, dirty);
    compared++; if (r !== 32'hCAFEF00D) begin failed++; $display("FAIL both_is_store: got %h want cafef00d", r); end
  endtask

  // Zero-wait instance with the request held high continuously; inputs
  // advance only after each RESP edge, like a stalled pipeline would.
  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic [7:0]  pat;
    int idx, nrsp;
    vals[0] = 32'h01020304; vals[1] = 32'h8899AABB;
    vals[2] = 32'hFFFF0000; vals[3] = 32'h13579BDF;
    idx = 0; nrsp = 0; pat = 8'd0;
    wr0 = 1'b1; mask0 = MASK_W; addr0 = 32'h80; wdata0 = vals[0];
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = rsp0;
      if (rsp0) begin nrsp++; idx++; end
      @(posedge clk); #1;
      if (idx < 4) begin addr0 = 32'h80 + 32'(4 * idx); wdata0 = vals[idx]; end
      else wr0 = 1'b0;
    end
    compared++; if (nrsp !== 4) begin failed++; $display("FAIL b2b_store_count: got %0d want 4", nrsp); end
    idx = 0; nrsp = 0; pat = 8'd0;
    rd0 = 1'b1; addr0 = 32'h80;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      pat[k] = rsp0;
      if (rsp0) begin
        compared++; if (idx > 3 || rdd0 !== vals[idx & 3]) begin failed++; $display("FAIL b2b_load_data%0d: got %h want %h", idx, rdd0, vals[idx & 3]); end
        nrsp++; idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) addr0 = 32'h80 + 32'(4 * idx);
      else rd0 = 1'b0;
    end
    compared++; if (nrsp !== 4) begin failed++; $display("FAIL b2b_load_count: got %0d want 4", nrsp); end
    compared++; if (pat !== 8'b1010_1010) begin failed++; $display("FAIL b2b_rsp_pattern: got %b want 10101010", pat); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misaligned();
    test_reset_wait();
    test_wrap_and_both();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words held; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each access; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 mem_rd  input  1  load request from M stage.
REQ-006 mem_wr  input  1  store request from M stage.
REQ-007 addr  input  32  byte address.
REQ-008 wr_data  input  32  store data, right-aligned.
REQ-009 mask  input  3  funct3 access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 busy  output  1  stall to pipeline; M/W registers hold while high.
REQ-011 rsp_valid  output  1  one-cycle pulse; access complete.
REQ-012 rd_data  output  32  load result, extended; valid only with rsp_valid.
REQ-013 err  output  1  misaligned or illegal mask; valid only with rsp_valid.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-015 In IDLE, when mem_rd or mem_wr is high, the block SHALL latch addr, wr_data, mask and op, then enter WAIT with counter=WAIT_CYCLES; with WAIT_CYCLES=0 it SHALL enter RESP directly.
REQ-016 In WAIT the counter SHALL decrement each cycle; at counter==1 the next state SHALL be RESP.
REQ-017 The access (array write or read) SHALL occur on the edge entering RESP; RESP SHALL last exactly one cycle, then return to IDLE.
REQ-018 Load latency: rsp_valid SHALL rise WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 busy SHALL be high in WAIT, high in IDLE while a request is present, and low in RESP, so the pipeline advances on the RESP edge.
REQ-020 Inputs SHALL be ignored outside IDLE; a request present in the RESP cycle SHALL NOT be accepted until the following IDLE cycle.
REQ-021 Stores SHALL write only enabled byte lanes: B writes lane addr[1:0] with wr_data[7:0]; H writes lanes {addr[1],0} and {addr[1],1} with wr_data[15:0]; W writes all four lanes.
REQ-022 Loads SHALL return the selected byte/halfword sign-extended for B/H, zero-extended for BU/HU, and the full word for W.
REQ-023 Word index SHALL be addr[2+log2(DEPTH)-1:2]; upper address bits SHALL be ignored (aliasing wrap-around).
REQ-024 H/HU with addr[0]=1, W with addr[1:0]!=0, or mask not in the legal set SHALL skip the array, go IDLE->RESP in one cycle, and assert err=1 with rd_data=0.
REQ-025 mem_rd and mem_wr both high SHALL be executed as a store; rd_data SHALL be 0.
REQ-026 For stores, rd_data SHALL be 0 in RESP.
REQ-027 rsp_valid, err and rd_data SHALL be 0 in every non-RESP cycle.

Reset
REQ-028 With rst low at an edge, the state SHALL be IDLE, counter 0 and latched request cleared; busy, rsp_valid, err and rd_data SHALL be 0 the cycle after reset.
REQ-029 A reset during WAIT SHALL abort the access; no array write SHALL occur.
REQ-030 Array contents SHALL NOT be cleared by reset.

Structure
REQ-031 The mask encodings (MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU) and the state enum SHALL live in shared package mem_pkg, which main_ctrl also imports.
REQ-032 Load alignment/extension SHALL be a combinational sub-module load_ext (inputs word, addr[1:0], mask; output 32-bit result).
REQ-033 Storage SHALL be a per-byte-lane array inferable as RAM with byte write enables.

Verification
REQ-034 SW 0xDEADBEEF @0x10, then LW @0x10, WAIT_CYCLES=2 -> rd_data=0xDEADBEEF, rsp_valid 3 cycles after accept, busy high for exactly 3 cycles.
REQ-035 SB 0x80 @0x13 over word 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-036 SH 0xBEEF @0x22, then LH @0x22 -> 0xFFFFBEEF; LHU @0x22 -> 0x0000BEEF.
REQ-037 LW @0x11 -> err=1, rd_data=0, rsp_valid one cycle after accept, memory unchanged.
REQ-038 SW 0x12345678 @0x40 with rst low during WAIT -> outputs 0 next cycle; LW @0x40 returns the prior value.
REQ-039 DEPTH=256: SW 0xA5A5A5A5 @0x400, then LW @0x000 -> 0xA5A5A5A5 (wrap); WAIT_CYCLES=0 back-to-back loads -> one rsp_valid per request.
